// File: rtl/acc_pkg.sv
// Shared types for the OFIFO psum accumulator.
//
// Contents:
//   COL, PSUM_BW, WORD_BW : default geometry (MAC columns, psum width, OFIFO word width)
//   acc_state_t           : drain FSM state {IDLE, DRAIN, DONE}
//   psum_lane_t           : one signed psum lane
//   lane_of()             : extract lane c from a packed OFIFO word (lane c is bits [(c+1)*PSUM_BW-1 -: PSUM_BW])
package acc_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int WORD_BW = COL * PSUM_BW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  typedef logic signed [PSUM_BW-1:0] psum_lane_t;

  function automatic psum_lane_t lane_of(input logic [WORD_BW-1:0] word, input int c);
    return word[c*PSUM_BW +: PSUM_BW];
  endfunction

endpackage

// File: rtl/psum_lane_relu.sv
// Combinational ReLU clamp for one psum lane on the readback path.
//
// Ports:
//   lane_in  in  psum_bw  two's-complement lane value
//   relu_en  in  1        when high, negative lanes are forced to zero
//   lane_out out psum_bw  clamped (or passed-through) lane value
module psum_lane_relu
  import acc_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic [psum_bw-1:0] lane_in,
  input  logic               relu_en,
  output logic [psum_bw-1:0] lane_out
);

  // The sign bit alone decides negativity; zero passes through unchanged.
  assign lane_out = (relu_en && lane_in[psum_bw-1]) ? '0 : lane_in;

endmodule

// File: rtl/ofifo_psum_accumulator.sv
// Drains column psums from the MAC array OFIFO and accumulates them per
// output pixel (nij) across kernel positions (kij). Once the run finishes the
// accumulated outputs can be read back with one cycle of latency, optionally
// through a ReLU clamp.
//
// Handshake: the OFIFO is first-word-fall-through. ofifo_valid says the head
// word on ofifo_out is real; ofifo_rd is asserted in the same cycle to pop it,
// and the pop (and the matching accumulator write) happens on the next rising
// clk edge. ofifo_rd is only ever high while ofifo_valid is high.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  one-cycle run request, honoured only in IDLE
//   num_nij, num_kij       words per pass and number of passes, latched at start
//   ofifo_valid, ofifo_out OFIFO head status and word
//   ofifo_rd               OFIFO pop request (combinational)
//   busy                   high from the cycle after start until the DONE cycle inclusive
//   done                   one-cycle completion pulse
//   relu_en                clamp negative lanes on readback
//   rd_en, rd_addr         readback request and nij index (ignored while busy)
//   rd_data                registered readback word
//   dbg_state              current FSM state
module ofifo_psum_accumulator
  import acc_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int max_nij = 64,
  parameter int cnt_bw  = $clog2(max_nij + 1),
  parameter int kij_bw  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [cnt_bw-1:0]      num_nij,
  input  logic [kij_bw-1:0]      num_kij,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   busy,
  output logic                   done,
  input  logic                   relu_en,
  input  logic                   rd_en,
  input  logic [cnt_bw-1:0]      rd_addr,
  output logic [col*psum_bw-1:0] rd_data,
  output acc_state_t             dbg_state
);

  localparam int AW = (max_nij > 1) ? $clog2(max_nij) : 1;
  localparam int WW = col * psum_bw;
  localparam logic [cnt_bw-1:0] ADDR_LIMIT = cnt_bw'(max_nij);

  acc_state_t        state;
  logic [cnt_bw-1:0] nij_cnt;
  logic [cnt_bw-1:0] num_nij_q;
  logic [kij_bw-1:0] kij_cnt;
  logic [kij_bw-1:0] num_kij_q;

  logic              pop;
  logic              last_nij;
  logic              last_kij;

  // Accumulator file: deliberately not reset, the kij==0 pass initialises it.
  logic [WW-1:0]     acc [max_nij];
  logic [AW-1:0]     wr_idx;
  logic [WW-1:0]     acc_cur;
  logic [WW-1:0]     acc_next;

  logic              rd_in_range;
  logic [WW-1:0]     rd_word;
  logic [WW-1:0]     rd_clamped;

  // ---------------------------------------------------------------------------
  // Pop control
  // ---------------------------------------------------------------------------
  assign pop       = (state == DRAIN) && ofifo_valid;
  assign ofifo_rd  = pop;
  assign last_nij  = (nij_cnt == num_nij_q - cnt_bw'(1));
  assign last_kij  = (kij_cnt == num_kij_q - kij_bw'(1));
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Drain FSM with counters and registered busy/done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      nij_cnt   <= '0;
      kij_cnt   <= '0;
      num_nij_q <= '0;
      num_kij_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_nij_q <= num_nij;
            num_kij_q <= num_kij;
            nij_cnt   <= '0;
            kij_cnt   <= '0;
            busy      <= 1'b1;
            // An empty run still produces a done pulse so the caller never waits forever.
            if ((num_nij == '0) || (num_kij == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Counters only move on a pop, so valid gaps simply stall the run.
          if (ofifo_valid) begin
            if (last_nij) begin
              nij_cnt <= '0;
              kij_cnt <= kij_cnt + kij_bw'(1);
              if (last_kij) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              nij_cnt <= nij_cnt + cnt_bw'(1);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate datapath
  // ---------------------------------------------------------------------------
  assign wr_idx  = nij_cnt[AW-1:0];
  assign acc_cur = acc[wr_idx];

  // Readback source; out-of-range addresses read as zero.
  assign rd_in_range = (rd_addr < ADDR_LIMIT);
  assign rd_word     = rd_in_range ? acc[rd_addr[AW-1:0]] : '0;

  for (genvar c = 0; c < col; c++) begin : g_lane
    logic signed [psum_bw-1:0] base_l;
    logic signed [psum_bw-1:0] in_l;

    // First pass overwrites whatever is in the file; later passes add on.
    assign base_l = (kij_cnt == '0) ? '0 : acc_cur[c*psum_bw +: psum_bw];
    assign in_l   = ofifo_out[c*psum_bw +: psum_bw];
    // psum_bw-wide signed add: wraps in two's complement, never saturates.
    assign acc_next[c*psum_bw +: psum_bw] = base_l + in_l;

    psum_lane_relu #(
      .psum_bw (psum_bw)
    ) u_relu (
      .lane_in  (rd_word[c*psum_bw +: psum_bw]),
      .relu_en  (relu_en),
      .lane_out (rd_clamped[c*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      acc[wr_idx] <= acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Readback register: only loads in IDLE, otherwise holds
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en && (state == IDLE)) begin
      rd_data <= rd_clamped;
    end
  end

endmodule

// File: tb/tb_ofifo_psum_accumulator.sv
module tb_ofifo_psum_accumulator;
  import acc_pkg::*;

  localparam int W    = WORD_BW;
  localparam int MAXN = 64;
  localparam int CB   = $clog2(MAXN + 1);
  localparam int KB   = 4;

  localparam int P_INC  = 0;
  localparam int P_COL  = 1;
  localparam int P_WRAP = 2;
  localparam int P_RAND = 3;
  localparam int V_HIGH   = 0;
  localparam int V_TOGGLE = 1;
  localparam int V_RAND   = 2;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [CB-1:0] num_nij;
  logic [KB-1:0] num_kij;
  logic          ofifo_valid;
  logic [W-1:0]  ofifo_out;
  logic          ofifo_rd;
  logic          busy;
  logic          done;
  logic          relu_en;
  logic          rd_en;
  logic [CB-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  acc_state_t    dbg_state;

  ofifo_psum_accumulator #(
    .col     (COL),
    .psum_bw (PSUM_BW),
    .max_nij (MAXN),
    .kij_bw  (KB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .num_nij     (num_nij),
    .num_kij     (num_kij),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .busy        (busy),
    .done        (done),
    .relu_en     (relu_en),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .dbg_state   (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] last_rd;
  logic signed [PSUM_BW-1:0] model_acc [MAXN][COL];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model
  function automatic logic [W-1:0] gen_word(input int pat, input int nij, input int kij);
    logic [W-1:0] w;
    w = '0;
    for (int c = 0; c < COL; c++) begin
      case (pat)
        P_INC:   w[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(nij + 1);
        P_COL:   w[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(c - 3);
        P_WRAP:  if (c == 0) w[PSUM_BW-1:0] = (kij == 0) ? 16'h7FFF : 16'h0001;
        default: w[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
      endcase
    end
    return w;
  endfunction

  // Word k of the stream belongs to pixel k mod n of pass k div n.
  task automatic model_pop(input int k, input int n, input logic [W-1:0] w);
    int nij;
    int kij;
    nij = k % n;
    kij = k / n;
    for (int c = 0; c < COL; c++) begin
      if (kij == 0) model_acc[nij][c] = lane_of(w, c);
      else          model_acc[nij][c] = model_acc[nij][c] + lane_of(w, c);
    end
  endtask

  function automatic logic [W-1:0] model_word(input int a, input bit relu);
    logic [W-1:0] w;
    logic signed [PSUM_BW-1:0] v;
    w = '0;
    if (a < MAXN) begin
      for (int c = 0; c < COL; c++) begin
        v = model_acc[a][c];
        if (relu && (v < 0)) v = '0;
        w[c*PSUM_BW +: PSUM_BW] = v;
      end
    end
    return w;
  endfunction

  // Driver: one full run, checking the handshake every cycle
  task automatic do_run(input int n, input int k, input int pat, input int vmode,
                        input int restart_at, input int exp_done);
    int total;
    int pops;
    int act_pops;
    int phase;
    int done_cyc;
    int cyc;
    bit v;
    total = n * k;
    fifo_q.delete();
    for (int i = 0; i < total; i++) fifo_q.push_back(gen_word(pat, i % n, i / n));

    @(negedge clk);
    start = 1'b1; num_nij = CB'(n); num_kij = KB'(k);
    ofifo_valid = 1'b0; rd_en = 1'b0;
    #1;
    check("busy_before_start", busy, 0);
    check("rd_before_start", ofifo_rd, 0);

    pops = 0; act_pops = 0; phase = 0; done_cyc = -1; cyc = 0;
    while (phase < 2 && cyc < 4 * total + 20) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      case (vmode)
        V_HIGH:   v = 1'b1;
        V_TOGGLE: v = cyc[0];
        default:  v = 1'($urandom_range(0, 1));
      endcase
      ofifo_valid = v;
      ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : {4{$urandom}};
      rd_en       = (phase == 0);
      rd_addr     = CB'($urandom_range(0, MAXN - 1));
      relu_en     = 1'($urandom_range(0, 1));
      #1;
      if (ofifo_rd) act_pops++;
      if (pops < total) begin
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        check("ofifo_rd", ofifo_rd, v);
        if (v) begin
          model_pop(pops, n, fifo_q.pop_front());
          pops++;
        end
      end else if (phase == 0) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_no_pop", ofifo_rd, 0);
        done_cyc = cyc;
        phase = 1;
      end else begin
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        phase = 2;
      end
    end
    start = 1'b0; ofifo_valid = 1'b0; rd_en = 1'b0;

    if (phase < 2) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: run n=%0d k=%0d did not finish within %0d cycles", n, k, cyc);
    end
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    check("pop_count", act_pops, total);
    check("rd_hold_busy", rd_data, last_rd);
  endtask

  task automatic read_check(input int a, input bit relu, input logic [W-1:0] exp, input string name);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = CB'(a); relu_en = relu;
    exp_q.push_back(exp);
    @(negedge clk);
    rd_en = 1'b0; rd_addr = CB'($urandom_range(0, MAXN - 1));
    check(name, rd_data, exp_q.pop_front());
    last_rd = exp;
    @(negedge clk);
    check("rd_hold_idle", rd_data, last_rd);
  endtask

  // Stimulus table: {inputs, expected done cycle (-1 = stall-dependent)}
  typedef struct {
    int n;
    int k;
    int pat;
    int vmode;
    int restart_at;
    int exp_done;
  } run_vec_t;

  run_vec_t vecs [7];

  initial begin
    logic [W-1:0] w_sum;
    logic [W-1:0] w_relu;
    int col_sum  [COL];
    int col_relu [COL];
    bit r;

    col_sum  = '{-9, -6, -3, 0, 3, 6, 9, 12};
    col_relu = '{0, 0, 0, 0, 3, 6, 9, 12};

    vecs[0] = '{n: 8,  k: 2, pat: P_RAND, vmode: V_HIGH, restart_at: 3,  exp_done: 17};
    vecs[1] = '{n: 5,  k: 0, pat: P_RAND, vmode: V_HIGH, restart_at: -1, exp_done: 1};
    vecs[2] = '{n: 0,  k: 3, pat: P_RAND, vmode: V_HIGH, restart_at: -1, exp_done: 1};
    vecs[3] = '{n: 12, k: 4, pat: P_RAND, vmode: V_RAND, restart_at: -1, exp_done: -1};
    vecs[4] = '{n: 1,  k: 5, pat: P_RAND, vmode: V_HIGH, restart_at: 2,  exp_done: 6};
    vecs[5] = '{n: 64, k: 2, pat: P_RAND, vmode: V_RAND, restart_at: -1, exp_done: -1};
    vecs[6] = '{n: 3,  k: 1, pat: P_RAND, vmode: V_TOGGLE, restart_at: -1, exp_done: 6};

    // Reset block
    reset_n = 1'b0; start = 1'b0; num_nij = '0; num_kij = '0;
    ofifo_valid = 1'b1; ofifo_out = '0; relu_en = 1'b0; rd_en = 1'b0; rd_addr = '0;
    last_rd = '0;
    #12;
    check("reset_ofifo_rd", ofifo_rd, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_state", dbg_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1; ofifo_valid = 1'b0;

    // Single pass, lanes = nij+1, done 5 cycles after start
    do_run(4, 1, P_INC, V_HIGH, -1, 5);
    for (int a = 0; a < 4; a++) read_check(a, 1'b0, {COL{16'(a + 1)}}, "single_pass");

    // Three passes with valid toggling: every lane 3*(c-3)
    do_run(16, 3, P_COL, V_TOGGLE, -1, -1);
    for (int c = 0; c < COL; c++) begin
      w_sum[c*PSUM_BW +: PSUM_BW]  = PSUM_BW'(col_sum[c]);
      w_relu[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(col_relu[c]);
    end
    read_check(0, 1'b0, w_sum, "three_pass_a0");
    read_check(15, 1'b0, w_sum, "three_pass_a15");
    read_check(7, 1'b1, w_relu, "relu_a7");
    read_check(15, 1'b1, w_relu, "relu_a15");
    read_check(64, 1'b0, '0, "addr_out_of_range");

    // Wrap: 0x7FFF + 0x0001 -> 0x8000, no saturation
    do_run(2, 2, P_WRAP, V_HIGH, -1, 5);
    read_check(0, 1'b0, W'(16'h8000), "wrap_a0");
    read_check(1, 1'b0, W'(16'h8000), "wrap_a1");
    read_check(1, 1'b1, '0, "wrap_relu");

    // Reset asserted mid-DRAIN
    @(negedge clk);
    start = 1'b1; num_nij = CB'(16); num_kij = KB'(2);
    @(negedge clk);
    start = 1'b0; ofifo_valid = 1'b1; ofifo_out = {4{$urandom}};
    repeat (5) @(negedge clk);
    check("mid_run_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ofifo_rd", ofifo_rd, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_rd_data", rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1; ofifo_valid = 1'b0;
    last_rd = '0;
    do_run(6, 2, P_RAND, V_HIGH, -1, 13);
    for (int a = 0; a < 6; a++) read_check(a, 1'b0, model_word(a, 1'b0), "post_reset_run");

    // Table-driven randomized runs against the model
    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].n, vecs[i].k, vecs[i].pat, vecs[i].vmode, vecs[i].restart_at, vecs[i].exp_done);
      if (vecs[i].k > 0) begin
        for (int a = 0; a < vecs[i].n; a++) begin
          r = 1'($urandom_range(0, 1));
          read_check(a, r, model_word(a, r), "table_readback");
        end
      end
      read_check(MAXN + $urandom_range(0, MAXN - 1), 1'b0, '0, "table_out_of_range");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
